rot_column_scanner: RTL and testbench
=====================================

Name: rot_column_scanner

Overview:
Read-side consumer of the rotational frame buffer.
- On each new angular position from the encoder/hall tracker, it addresses the buffer with theta_read and waits the fixed read latency.
- It then captures the two opposing columns (theta and theta+pi) with their radii.
- It serializes both columns to the two LED arm driver chains, then latches them.
- It sits between the angle tracker, the frame buffer's read port, and the LED driver pins.

Parameters:
ROTATIONAL_RES, 1024, angular steps per revolution
DISPLAY_RADIUS, 32, radial positions per arm
DISPLAY_HEIGHT, 64, LEDs per column (bits shifted per lane)
READ_LATENCY, 2, cycles from theta_read stable to valid columns_in
SCLK_DIV, 4, clk_in cycles per sclk half-period (>=1)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
theta_in  input  $clog2(ROTATIONAL_RES)  current angle from tracker
theta_valid  input  1  one-cycle pulse: theta_in updated
buf_busy  input  1  frame buffer busy (write/flush in progress)
columns_in  input  2x DISPLAY_HEIGHT  buffer read data, [0]=theta, [1]=theta+pi
radii_in  input  2x $clog2(DISPLAY_RADIUS)  buffer radii, same order
theta_read  output  $clog2(ROTATIONAL_RES)  buffer read address
sdata_out  output  2  serial data, lane0=arm0, lane1=arm1
sclk_out  output  1  shift clock to LED drivers
latch_out  output  1  latch strobe to LED drivers
radii_out  output  2x $clog2(DISPLAY_RADIUS)  radii of currently latched columns
frame_done  output  1  one-cycle pulse after latch completes
overrun  output  1  sticky: a theta_valid was dropped; cleared only by reset

Behaviour:
- Reset values: theta_read=0, sdata_out=0, sclk_out=0, latch_out=0, radii_out=0, frame_done=0, overrun=0, state IDLE, pending=0.
- Reset is asynchronous. Asserting it mid-shift drops all outputs to reset values immediately, with no partial latch.
- States: IDLE, REQUEST, SHIFT, LATCH.
- IDLE:
  - On theta_valid, register theta_in into theta_read and go to REQUEST. The read counter is 0.
  - If pending=1, use the pending theta instead.
- REQUEST:
  - theta_read is held constant.
  - The counter increments each cycle buf_busy=0. Any cycle with buf_busy=1 resets the counter to 0, so the window restarts.
  - When the counter reaches READ_LATENCY, capture columns_in/radii_in into shift registers and go to SHIFT.
  - Minimum capture is READ_LATENCY+1 cycles after theta_valid.
- SHIFT:
  - Each bit spends SCLK_DIV cycles with sclk low, then SCLK_DIV cycles with sclk high.
  - sdata changes only while sclk is low, on the first low cycle.
  - Order is MSB first (z=DISPLAY_HEIGHT-1 first), both lanes in parallel.
  - After DISPLAY_HEIGHT rising edges, go to LATCH with sclk low.
- LATCH:
  - latch_out is high for SCLK_DIV cycles. radii_out updates on the first latch cycle.
  - Then latch drops, frame_done pulses for one cycle, and the block returns to IDLE.
- theta_valid outside IDLE:
  - Store theta_in as pending, overwriting any older pending value.
  - If pending was already 1, set overrun.
  - A theta_valid arriving in the same cycle that IDLE consumes the pending value counts as a drop and sets overrun. The newer theta becomes pending.
- Angle wrap: theta_in=ROTATIONAL_RES-1 followed by 0 needs no special handling. theta_read carries theta_in unmodified.
- Frame time = READ_LATENCY+1 + 2*SCLK_DIV*DISPLAY_HEIGHT + SCLK_DIV + 1 cycles with no busy stall. For defaults: 3+512+4+1 = 520.

Decomposition:
- Package rot_display_pkg holds:
  - the ROTATIONAL_RES, DISPLAY_RADIUS and DISPLAY_HEIGHT defaults;
  - theta_t and radius_t typedefs;
  - the scanner_state_t enum (IDLE, REQUEST, SHIFT, LATCH).
- Sub-module led_shift_serializer:
  - two-lane parallel-load shift register plus sclk divider;
  - load/start input, done output;
  - parameters DISPLAY_HEIGHT, SCLK_DIV.
- The scanner FSM owns request, latch and pending logic.

Test Plan:
- Single request: theta_valid with theta_in=10, buf_busy=0, columns_in[0]=64'h8000_0000_0000_0001, columns_in[1]=64'h1, radii=5/7 -> theta_read=10 until capture. Lane0 shows 1, 62 zeros, then 1. Lane1 shows 63 zeros, then 1. latch_out high 4 cycles. radii_out={7,5}. frame_done at cycle 520.
- Busy stall: buf_busy=1 for 5 cycles starting 1 cycle after request -> capture delayed exactly 5 cycles. Captured data is the value present READ_LATENCY idle cycles after busy drops.
- Pending/overrun: theta_valid 20 during SHIFT, then 21 during SHIFT -> overrun=1. Next frame reads theta 21. Theta 20 is never presented.
- Single pending no overrun: one theta_valid 30 mid-frame -> second frame starts the cycle after frame_done with theta_read=30. overrun stays 0.
- Wrap: theta 1023 then 0 -> theta_read 1023, then 0. Both frames complete normally.
- Reset mid-shift: rst_in low at bit 20 -> sclk, sdata, latch and radii go to 0 asynchronously. After release, no latch pulse until a new theta_valid.

Source files
------------

// File: rtl/rot_display_pkg.sv
// Shared defaults and types for the rotational display read path.
package rot_display_pkg;

    localparam int DEF_ROTATIONAL_RES = 1024;
    localparam int DEF_DISPLAY_RADIUS = 32;
    localparam int DEF_DISPLAY_HEIGHT = 64;

    typedef logic [$clog2(DEF_ROTATIONAL_RES)-1:0] theta_t;
    typedef logic [$clog2(DEF_DISPLAY_RADIUS)-1:0] radius_t;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SHIFT,
        LATCH
    } scanner_state_t;

endpackage

// File: rtl/led_shift_serializer.sv
// Two-lane parallel-load shift register with divided shift clock, MSB first.
module led_shift_serializer #(
    parameter int DISPLAY_HEIGHT = 64,
    parameter int SCLK_DIV       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [DISPLAY_HEIGHT-1:0] col0_in,
    input  logic [DISPLAY_HEIGHT-1:0] col1_in,
    output logic [1:0]                sdata,
    output logic                      sclk,
    output logic                      done
);
    localparam int DW = $clog2(SCLK_DIV + 1);
    localparam int BW = $clog2(DISPLAY_HEIGHT + 1);

    logic [DISPLAY_HEIGHT-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic                      active_q, active_d;
    logic                      sclk_q, sclk_d;
    logic [DW-1:0]             div_q, div_d;
    logic [BW-1:0]             bit_q, bit_d;

    always_comb begin
        sh0_d    = sh0_q;
        sh1_d    = sh1_q;
        active_d = active_q;
        sclk_d   = sclk_q;
        div_d    = div_q;
        bit_d    = bit_q;
        done     = 1'b0;
        if (load) begin
            sh0_d    = col0_in;
            sh1_d    = col1_in;
            active_d = 1'b1;
            sclk_d   = 1'b0;
            div_d    = '0;
            bit_d    = '0;
        end else if (active_q) begin
            if (div_q == DW'(SCLK_DIV - 1)) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // Falling sclk is the only point where the data lanes advance.
                    sclk_d = 1'b0;
                    if (bit_q == BW'(DISPLAY_HEIGHT - 1)) begin
                        active_d = 1'b0;
                        done     = 1'b1;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        sh0_d = sh0_q << 1;
                        sh1_d = sh1_q << 1;
                    end
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh0_q    <= '0;
            sh1_q    <= '0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
        end else begin
            sh0_q    <= sh0_d;
            sh1_q    <= sh1_d;
            active_q <= active_d;
            sclk_q   <= sclk_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
        end
    end

    assign sdata = active_q ? {sh1_q[DISPLAY_HEIGHT-1], sh0_q[DISPLAY_HEIGHT-1]} : 2'b00;
    assign sclk  = sclk_q;

endmodule

// File: rtl/rot_column_scanner.sv
// Per-angle column fetch from the frame buffer and serial drive of both LED arms.
module rot_column_scanner
    import rot_display_pkg::*;
#(
    parameter int ROTATIONAL_RES = DEF_ROTATIONAL_RES,
    parameter int DISPLAY_RADIUS = DEF_DISPLAY_RADIUS,
    parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
    parameter int READ_LATENCY   = 2,
    parameter int SCLK_DIV       = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0]   theta_in,
    input  logic                                theta_valid,
    input  logic                                buf_busy,
    input  logic [2*DISPLAY_HEIGHT-1:0]         columns_in,
    input  logic [2*$clog2(DISPLAY_RADIUS)-1:0] radii_in,
    output logic [$clog2(ROTATIONAL_RES)-1:0]   theta_read,
    output logic [1:0]                          sdata_out,
    output logic                                sclk_out,
    output logic                                latch_out,
    output logic [2*$clog2(DISPLAY_RADIUS)-1:0] radii_out,
    output logic                                frame_done,
    output logic                                overrun
);
    localparam int TW = $clog2(ROTATIONAL_RES);
    localparam int RW = $clog2(DISPLAY_RADIUS);
    localparam int CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int LW = $clog2(SCLK_DIV + 1);

    scanner_state_t  state_q, state_d;
    logic [TW-1:0]   theta_read_q, theta_read_d;
    logic [TW-1:0]   pend_theta_q, pend_theta_d;
    logic            pending_q, pending_d;
    logic            overrun_q, overrun_d;
    logic [CW-1:0]   req_cnt_q, req_cnt_d;
    logic [LW-1:0]   latch_cnt_q, latch_cnt_d;
    logic            latch_q, latch_d;
    logic            frame_done_q, frame_done_d;
    logic [2*RW-1:0] cap_radii_q, cap_radii_d;
    logic [2*RW-1:0] radii_out_q, radii_out_d;
    logic            ser_load;
    logic            ser_done;

    always_comb begin
        state_d      = state_q;
        theta_read_d = theta_read_q;
        pend_theta_d = pend_theta_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        req_cnt_d    = req_cnt_q;
        latch_cnt_d  = latch_cnt_q;
        latch_d      = latch_q;
        frame_done_d = 1'b0;
        cap_radii_d  = cap_radii_q;
        radii_out_d  = radii_out_q;
        ser_load     = 1'b0;

        if (theta_valid && state_q != IDLE) begin
            pending_d    = 1'b1;
            pend_theta_d = theta_in;
            if (pending_q) overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    theta_read_d = pend_theta_q;
                    pending_d    = 1'b0;
                    req_cnt_d    = '0;
                    state_d      = REQUEST;
                    // A new angle arriving while the old one is consumed displaces nothing
                    // useful yet, but the older request was still late: flag it.
                    if (theta_valid) begin
                        pending_d    = 1'b1;
                        pend_theta_d = theta_in;
                        overrun_d    = 1'b1;
                    end
                end else if (theta_valid) begin
                    theta_read_d = theta_in;
                    req_cnt_d    = '0;
                    state_d      = REQUEST;
                end
            end
            REQUEST: begin
                if (buf_busy) begin
                    req_cnt_d = '0;
                end else if (req_cnt_q == CW'(READ_LATENCY)) begin
                    ser_load    = 1'b1;
                    cap_radii_d = radii_in;
                    state_d     = SHIFT;
                end else begin
                    req_cnt_d = req_cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (ser_done) begin
                    state_d     = LATCH;
                    latch_d     = 1'b1;
                    latch_cnt_d = '0;
                    radii_out_d = cap_radii_q;
                end
            end
            LATCH: begin
                // frame_done rises together with the return to IDLE, so a queued angle
                // starts on the cycle right after the pulse.
                if (latch_cnt_q == LW'(SCLK_DIV - 1)) begin
                    latch_d      = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    latch_cnt_d = latch_cnt_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            theta_read_q <= '0;
            pend_theta_q <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            req_cnt_q    <= '0;
            latch_cnt_q  <= '0;
            latch_q      <= 1'b0;
            frame_done_q <= 1'b0;
            cap_radii_q  <= '0;
            radii_out_q  <= '0;
        end else begin
            state_q      <= state_d;
            theta_read_q <= theta_read_d;
            pend_theta_q <= pend_theta_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            req_cnt_q    <= req_cnt_d;
            latch_cnt_q  <= latch_cnt_d;
            latch_q      <= latch_d;
            frame_done_q <= frame_done_d;
            cap_radii_q  <= cap_radii_d;
            radii_out_q  <= radii_out_d;
        end
    end

    led_shift_serializer #(
        .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
        .SCLK_DIV      (SCLK_DIV)
    ) u_serializer (
        .clk    (clk_in),
        .rst_n  (rst_in),
        .load   (ser_load),
        .col0_in(columns_in[DISPLAY_HEIGHT-1:0]),
        .col1_in(columns_in[2*DISPLAY_HEIGHT-1:DISPLAY_HEIGHT]),
        .sdata  (sdata_out),
        .sclk   (sclk_out),
        .done   (ser_done)
    );

    assign theta_read = theta_read_q;
    assign latch_out  = latch_q;
    assign radii_out  = radii_out_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rot_column_scanner.sv
// Self-checking bench for rot_column_scanner against a frame-level reference model.
module tb_rot_column_scanner;
    import rot_display_pkg::*;

    localparam int RES   = 1024;
    localparam int H     = 64;
    localparam int RL    = 2;
    localparam int DIV   = 4;
    localparam int TW    = 10;
    localparam int RW    = 5;
    localparam int FRAME = RL + 1 + 2 * DIV * H + DIV + 1;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [TW-1:0]     theta_in;
    logic              theta_valid;
    logic              buf_busy;
    logic [2*H-1:0]    columns_in;
    logic [2*RW-1:0]   radii_in;
    logic [TW-1:0]     theta_read;
    logic [1:0]        sdata_out;
    logic              sclk_out;
    logic              latch_out;
    logic [2*RW-1:0]   radii_out;
    logic              frame_done;
    logic              overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Monitor state: reconstructed serial columns, latch activity, completed frames
    int            clr_req = 0;
    int            clr_seen = 0;
    logic [H-1:0]  lane0_obs = '0;
    logic [H-1:0]  lane1_obs = '0;
    int            nbits = 0;
    int            latch_cycles = 0;
    int            sdata_viol = 0;
    logic [2*RW-1:0] radii_at_latch = '0;
    int            done_q[$];
    theta_t        theta_q[$];
    logic          prev_sclk = 1'b0;
    logic          prev_latch = 1'b0;
    logic [1:0]    prev_sdata = 2'b00;
    theta_t        prev_theta = '0;

    rot_column_scanner dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .theta_in   (theta_in),
        .theta_valid(theta_valid),
        .buf_busy   (buf_busy),
        .columns_in (columns_in),
        .radii_in   (radii_in),
        .theta_read (theta_read),
        .sdata_out  (sdata_out),
        .sclk_out   (sclk_out),
        .latch_out  (latch_out),
        .radii_out  (radii_out),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            lane0_obs = '0;
            lane1_obs = '0;
            nbits = 0;
            latch_cycles = 0;
            sdata_viol = 0;
            radii_at_latch = '0;
            done_q.delete();
            theta_q.delete();
        end
        if (sclk_out && !prev_sclk) begin
            lane0_obs = {lane0_obs[H-2:0], sdata_out[0]};
            lane1_obs = {lane1_obs[H-2:0], sdata_out[1]};
            nbits++;
        end
        if (sclk_out && prev_sclk && sdata_out != prev_sdata) sdata_viol++;
        if (latch_out) latch_cycles++;
        if (latch_out && !prev_latch) radii_at_latch = radii_out;
        if (frame_done) done_q.push_back(cyc);
        if (theta_read != prev_theta) theta_q.push_back(theta_read);
        prev_sclk  = sclk_out;
        prev_latch = latch_out;
        prev_sdata = sdata_out;
        prev_theta = theta_read;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic pulse(input logic [TW-1:0] th, output int t);
        theta_in = th;
        theta_valid = 1'b1;
        step(1);
        theta_valid = 1'b0;
        t = cyc;
    endtask

    task automatic clear_mon();
        clr_req++;
        step(2);
    endtask

    task automatic wait_done(input int n, input int limit, output bit ok);
        for (int i = 0; i < limit && done_q.size() < n; i++) step(1);
        ok = (done_q.size() >= n);
    endtask

    task automatic apply_reset();
        rst_in = 1'b0;
        step(3);
        rst_in = 1'b1;
        step(2);
    endtask

    function automatic int done_at(input int idx);
        return (done_q.size() > idx) ? done_q[idx] : -1;
    endfunction

    task automatic test_reset();
        rst_in = 1'b0;
        step(2);
        checks++; if (theta_read !== '0) begin errors++; $display("[TB] FAIL reset_theta_read: got %0d want 0", theta_read); end
        checks++; if (sdata_out !== 2'b00) begin errors++; $display("[TB] FAIL reset_sdata: got %b want 00", sdata_out); end
        checks++; if (sclk_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk: got %b want 0", sclk_out); end
        checks++; if (latch_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_latch: got %b want 0", latch_out); end
        checks++; if (radii_out !== '0) begin errors++; $display("[TB] FAIL reset_radii: got %h want 0", radii_out); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
        rst_in = 1'b1;
        step(5);
        checks++; if (latch_out !== 1'b0 || sclk_out !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: latch=%b sclk=%b want 0/0", latch_out, sclk_out); end
    endtask

    task automatic test_single();
        int t0;
        bit ok;
        logic [H-1:0] c0, c1;
        c0 = 64'h8000_0000_0000_0001;
        c1 = 64'h1;
        clear_mon();
        columns_in = {c1, c0};
        radii_in = {5'd7, 5'd5};
        buf_busy = 1'b0;
        pulse(10'd10, t0);
        checks++; if (theta_read !== 10'd10) begin errors++; $display("[TB] FAIL single_theta_start: got %0d want 10", theta_read); end
        step(RL);
        checks++; if (theta_read !== 10'd10) begin errors++; $display("[TB] FAIL single_theta_hold: got %0d want 10", theta_read); end
        wait_done(1, FRAME + 40, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout: got no frame_done want 1"); end
        checks++; if (done_at(0) - t0 !== FRAME - 1) begin errors++; $display("[TB] FAIL single_done_cycle: got %0d want %0d", done_at(0) - t0, FRAME - 1); end
        step(2);
        checks++; if (nbits !== H) begin errors++; $display("[TB] FAIL single_bit_count: got %0d want %0d", nbits, H); end
        checks++; if (lane0_obs !== c0) begin errors++; $display("[TB] FAIL single_lane0: got %h want %h", lane0_obs, c0); end
        checks++; if (lane1_obs !== c1) begin errors++; $display("[TB] FAIL single_lane1: got %h want %h", lane1_obs, c1); end
        checks++; if (latch_cycles !== DIV) begin errors++; $display("[TB] FAIL single_latch_len: got %0d want %0d", latch_cycles, DIV); end
        checks++; if (radii_at_latch !== {5'd7, 5'd5}) begin errors++; $display("[TB] FAIL single_radii_at_latch: got %h want %h", radii_at_latch, {5'd7, 5'd5}); end
        checks++; if (radii_out !== {5'd7, 5'd5}) begin errors++; $display("[TB] FAIL single_radii_out: got %h want %h", radii_out, {5'd7, 5'd5}); end
        checks++; if (sdata_viol !== 0) begin errors++; $display("[TB] FAIL single_sdata_stable: got %0d changes while sclk high want 0", sdata_viol); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL single_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_random();
        int t0;
        bit ok;
        logic [2*H-1:0] cols;
        logic [2*RW-1:0] rad;
        logic [TW-1:0] th;
        for (int f = 0; f < 3; f++) begin
            clear_mon();
            cols = {$urandom(), $urandom(), $urandom(), $urandom()};
            rad = {RW'($urandom_range(1, 31)), RW'($urandom_range(1, 31))};
            th = TW'($urandom_range(0, RES - 1));
            columns_in = cols;
            radii_in = rad;
            pulse(th, t0);
            checks++; if (theta_read !== th) begin errors++; $display("[TB] FAIL rand%0d_theta: got %0d want %0d", f, theta_read, th); end
            wait_done(1, FRAME + 40, ok);
            checks++; if (done_at(0) - t0 !== FRAME - 1) begin errors++; $display("[TB] FAIL rand%0d_done_cycle: got %0d want %0d", f, done_at(0) - t0, FRAME - 1); end
            step(2);
            checks++; if (lane0_obs !== cols[H-1:0]) begin errors++; $display("[TB] FAIL rand%0d_lane0: got %h want %h", f, lane0_obs, cols[H-1:0]); end
            checks++; if (lane1_obs !== cols[2*H-1:H]) begin errors++; $display("[TB] FAIL rand%0d_lane1: got %h want %h", f, lane1_obs, cols[2*H-1:H]); end
            checks++; if (radii_out !== rad) begin errors++; $display("[TB] FAIL rand%0d_radii: got %h want %h", f, radii_out, rad); end
        end
    endtask

    task automatic test_busy();
        int t0;
        bit ok;
        logic [2*H-1:0] good;
        logic [2*RW-1:0] grad;
        localparam int BUSY = 5;
        clear_mon();
        good = {$urandom(), $urandom(), $urandom(), $urandom()};
        grad = {RW'($urandom_range(1, 31)), RW'($urandom_range(1, 31))};
        columns_in = ~good;
        radii_in = ~grad;
        pulse(10'd300, t0);
        buf_busy = 1'b1;
        step(BUSY);
        buf_busy = 1'b0;
        // Data is valid only in the single cycle RL idle cycles after busy drops
        step(RL);
        columns_in = good;
        radii_in = grad;
        step(1);
        columns_in = ~good;
        radii_in = ~grad;
        wait_done(1, FRAME + BUSY + 40, ok);
        checks++; if (done_at(0) - t0 !== FRAME - 1 + BUSY) begin errors++; $display("[TB] FAIL busy_done_cycle: got %0d want %0d", done_at(0) - t0, FRAME - 1 + BUSY); end
        step(2);
        checks++; if (lane0_obs !== good[H-1:0]) begin errors++; $display("[TB] FAIL busy_lane0: got %h want %h", lane0_obs, good[H-1:0]); end
        checks++; if (lane1_obs !== good[2*H-1:H]) begin errors++; $display("[TB] FAIL busy_lane1: got %h want %h", lane1_obs, good[2*H-1:H]); end
        checks++; if (radii_out !== grad) begin errors++; $display("[TB] FAIL busy_radii: got %h want %h", radii_out, grad); end
    endtask

    task automatic test_wrap();
        int t0, t1;
        bit ok;
        clear_mon();
        columns_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        pulse(10'd1023, t0);
        step(RL);
        checks++; if (theta_read !== 10'd1023) begin errors++; $display("[TB] FAIL wrap_theta_hi: got %0d want 1023", theta_read); end
        wait_done(1, FRAME + 40, ok);
        pulse(10'd0, t1);
        checks++; if (theta_read !== 10'd0) begin errors++; $display("[TB] FAIL wrap_theta_zero: got %0d want 0", theta_read); end
        wait_done(2, FRAME + 40, ok);
        checks++; if (done_at(1) - t1 !== FRAME - 1) begin errors++; $display("[TB] FAIL wrap_second_done: got %0d want %0d", done_at(1) - t1, FRAME - 1); end
        step(2);
        checks++; if (lane0_obs !== columns_in[H-1:0]) begin errors++; $display("[TB] FAIL wrap_lane0: got %h want %h", lane0_obs, columns_in[H-1:0]); end
    endtask

    task automatic test_single_pending();
        int t0, tp;
        bit ok;
        clear_mon();
        pulse(10'd12, t0);
        step(100);
        pulse(10'd30, tp);
        wait_done(1, FRAME + 40, ok);
        checks++; if (done_at(0) - t0 !== FRAME - 1) begin errors++; $display("[TB] FAIL pend_first_done: got %0d want %0d", done_at(0) - t0, FRAME - 1); end
        checks++; if (theta_read !== 10'd12) begin errors++; $display("[TB] FAIL pend_theta_during_done: got %0d want 12", theta_read); end
        step(1);
        checks++; if (theta_read !== 10'd30) begin errors++; $display("[TB] FAIL pend_theta_next: got %0d want 30", theta_read); end
        wait_done(2, FRAME + 40, ok);
        checks++; if (done_at(1) - t0 !== 2 * FRAME - 1) begin errors++; $display("[TB] FAIL pend_second_done: got %0d want %0d", done_at(1) - t0, 2 * FRAME - 1); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL pend_overrun: got %b want 0", overrun); end
        checks++; if (theta_q.size() != 2 || theta_q[0] !== 10'd12 || theta_q[1] !== 10'd30) begin errors++; $display("[TB] FAIL pend_theta_seq: got %0d addresses want 12,30", theta_q.size()); end
    endtask

    task automatic test_pending_overrun();
        int t0, tp;
        bit ok;
        clear_mon();
        pulse(10'd5, t0);
        step(50);
        pulse(10'd20, tp);
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_first_pending: got %b want 0", overrun); end
        step(50);
        pulse(10'd21, tp);
        step(1);
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b want 1", overrun); end
        wait_done(2, 2 * FRAME + 60, ok);
        checks++; if (done_at(1) - t0 !== 2 * FRAME - 1) begin errors++; $display("[TB] FAIL ovr_second_done: got %0d want %0d", done_at(1) - t0, 2 * FRAME - 1); end
        step(FRAME + 20);
        checks++; if (done_q.size() !== 2) begin errors++; $display("[TB] FAIL ovr_frame_count: got %0d want 2", done_q.size()); end
        checks++; if (theta_q.size() != 2 || theta_q[0] !== 10'd5 || theta_q[1] !== 10'd21) begin errors++; $display("[TB] FAIL ovr_theta_seq: got %0d addresses want 5,21", theta_q.size()); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_same_cycle_drop();
        int t0, tp;
        bit ok;
        apply_reset();
        clear_mon();
        radii_in = {5'd1, 5'd2};
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL drop_overrun_cleared: got %b want 0", overrun); end
        pulse(10'd40, t0);
        step(100);
        pulse(10'd41, tp);
        wait_done(1, FRAME + 40, ok);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL drop_done_visible: got %b want 1", frame_done); end
        pulse(10'd42, tp);
        checks++; if (theta_read !== 10'd41) begin errors++; $display("[TB] FAIL drop_theta_next: got %0d want 41", theta_read); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL drop_overrun: got %b want 1", overrun); end
        wait_done(3, 2 * FRAME + 60, ok);
        checks++; if (done_at(2) - t0 !== 3 * FRAME - 1) begin errors++; $display("[TB] FAIL drop_third_done: got %0d want %0d", done_at(2) - t0, 3 * FRAME - 1); end
        checks++; if (theta_q.size() != 3 || theta_q[2] !== 10'd42) begin errors++; $display("[TB] FAIL drop_theta_seq: got %0d addresses want 40,41,42", theta_q.size()); end
    endtask

    task automatic test_reset_midshift();
        int t0, t1;
        bit ok;
        clear_mon();
        columns_in = '1;
        radii_in = {5'd3, 5'd9};
        pulse(10'd77, t0);
        // Bit 20 is high from RL+1+8*20+DIV edges after the request
        step(RL + 1 + 2 * DIV * 20 + DIV + 1);
        checks++; if (sclk_out !== 1'b1 || sdata_out !== 2'b11) begin errors++; $display("[TB] FAIL midshift_pre: got sclk=%b sdata=%b want 1/11", sclk_out, sdata_out); end
        #1;
        rst_in = 1'b0;
        #1;
        checks++; if (sclk_out !== 1'b0 || sdata_out !== 2'b00) begin errors++; $display("[TB] FAIL midshift_async_shift: got sclk=%b sdata=%b want 0/00", sclk_out, sdata_out); end
        checks++; if (latch_out !== 1'b0 || radii_out !== '0) begin errors++; $display("[TB] FAIL midshift_async_latch: got latch=%b radii=%h want 0/0", latch_out, radii_out); end
        checks++; if (theta_read !== '0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL midshift_async_state: got theta=%0d overrun=%b want 0/0", theta_read, overrun); end
        step(2);
        rst_in = 1'b1;
        clear_mon();
        step(FRAME + 20);
        checks++; if (latch_cycles !== 0 || done_q.size() !== 0) begin errors++; $display("[TB] FAIL midshift_no_latch: got latch=%0d done=%0d want 0/0", latch_cycles, done_q.size()); end
        pulse(10'd88, t1);
        wait_done(1, FRAME + 40, ok);
        checks++; if (done_at(0) - t1 !== FRAME - 1) begin errors++; $display("[TB] FAIL midshift_recover: got %0d want %0d", done_at(0) - t1, FRAME - 1); end
    endtask

    initial begin
        theta_in = '0;
        theta_valid = 1'b0;
        buf_busy = 1'b0;
        columns_in = '0;
        radii_in = '0;
        rst_in = 1'b0;
        test_reset();
        test_single();
        test_random();
        test_busy();
        test_wrap();
        test_single_pending();
        test_pending_overrun();
        test_same_cycle_drop();
        test_reset_midshift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion want finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
